// File: rtl/bp_pkg.sv
// ---------------------------------------------------------------------------
// bp_pkg
// Shared definitions for the bimodal/gshare branch predictor controller.
//  - default table index and statistics counter widths
//  - 2-bit saturating counter encodings (SNT/WNT/WT/ST); prediction is the MSB
//  - saturating increment/decrement helpers
// No ports (package).
// ---------------------------------------------------------------------------
package bp_pkg;

  localparam int BP_IDX_BITS = 6;
  localparam int BP_CNT_W    = 32;

  localparam logic [1:0] SNT = 2'b00;
  localparam logic [1:0] WNT = 2'b01;
  localparam logic [1:0] WT  = 2'b10;
  localparam logic [1:0] ST  = 2'b11;

  // Counters start weakly not-taken so one taken resolution flips the prediction
  localparam logic [1:0] CNT_RESET = WNT;

  function automatic logic [1:0] sat_inc(input logic [1:0] cnt);
    return (cnt == ST) ? ST : cnt + 2'd1;
  endfunction

  function automatic logic [1:0] sat_dec(input logic [1:0] cnt);
    return (cnt == SNT) ? SNT : cnt - 2'd1;
  endfunction

endpackage

// File: rtl/branch_predict_ctrl_if.sv
// ---------------------------------------------------------------------------
// branch_predict_ctrl_if
// Bundles the pipeline-facing signals of the branch predictor controller.
//  master : pipeline side (drives PC, stall/flush, resolution; sees prediction)
//  slave  : predictor side
// Signals:
//  PCF, StallF, StallD, FlushD, FlushE, StateUpdateEnable, Eval_branch,
//  Prediction_Correct           -> into the predictor
//  PredictF, MispredictE, BranchCount, MispredCount -> out of the predictor
// ---------------------------------------------------------------------------
interface branch_predict_ctrl_if
  import bp_pkg::*;
#(
  parameter int CNT_W = BP_CNT_W
) ();

  logic [31:0]      PCF;
  logic             StallF;
  logic             StallD;
  logic             FlushD;
  logic             FlushE;
  logic             StateUpdateEnable;
  logic             Eval_branch;
  logic             Prediction_Correct;
  logic             PredictF;
  logic             MispredictE;
  logic [CNT_W-1:0] BranchCount;
  logic [CNT_W-1:0] MispredCount;

  modport master (
    output PCF, StallF, StallD, FlushD, FlushE,
           StateUpdateEnable, Eval_branch, Prediction_Correct,
    input  PredictF, MispredictE, BranchCount, MispredCount
  );

  modport slave (
    input  PCF, StallF, StallD, FlushD, FlushE,
           StateUpdateEnable, Eval_branch, Prediction_Correct,
    output PredictF, MispredictE, BranchCount, MispredCount
  );

endinterface

// File: rtl/bp_counter_table.sv
// ---------------------------------------------------------------------------
// bp_counter_table
// ENTRIES x 2-bit saturating counter array with one asynchronous read port
// and one synchronous read-modify-write training port. The read port shows
// the stored value only (no write-to-read bypass).
// Ports:
//  clk, rst   clock / asynchronous active-high reset (all entries -> CNT_RESET)
//  i_rdIdx    lookup index
//  o_rdCnt    counter at i_rdIdx (combinational)
//  i_wrIdx    training index
//  i_taken    resolved direction: 1 increments, 0 decrements
//  i_we       training enable
// ---------------------------------------------------------------------------
module bp_counter_table
  import bp_pkg::*;
#(
  parameter int IDX_BITS = BP_IDX_BITS
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [IDX_BITS-1:0] i_rdIdx,
  output logic [1:0]          o_rdCnt,
  input  logic [IDX_BITS-1:0] i_wrIdx,
  input  logic                i_taken,
  input  logic                i_we
);

  localparam int ENTRIES = 1 << IDX_BITS;

  logic [1:0] r_table [ENTRIES];

  // Training saturates at both ends, so repeated taken jumps simply park at ST
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        r_table[i] <= CNT_RESET;
      end
    end else if (i_we) begin
      r_table[i_wrIdx] <= i_taken ? sat_inc(r_table[i_wrIdx])
                                  : sat_dec(r_table[i_wrIdx]);
    end
  end

  assign o_rdCnt = r_table[i_rdIdx];

endmodule

// File: rtl/branch_predict_ctrl.sv
// ---------------------------------------------------------------------------
// branch_predict_ctrl
// Bimodal branch predictor controller. Looks up a 2-bit counter for the
// fetch PC, carries the lookup index through decode to execute, trains that
// same entry at resolution and flags mispredictions.
// Ports:
//  clk   clock, rising edge
//  rst   asynchronous active-high reset
//  bus   branch_predict_ctrl_if.slave (PC, stall/flush, resolution in;
//        PredictF, MispredictE, BranchCount, MispredCount out)
// Configuration macro:
//  BRANCH_PREDICT_GSHARE_EN  when defined, the index is PC bits XOR a
//                            non-speculative global history register.
// ---------------------------------------------------------------------------
module branch_predict_ctrl
  import bp_pkg::*;
#(
  parameter int IDX_BITS = BP_IDX_BITS,
  parameter int CNT_W    = BP_CNT_W
) (
  input  logic                  clk,
  input  logic                  rst,
  branch_predict_ctrl_if.slave  bus
);

  logic [IDX_BITS-1:0] w_idxF;
  logic [IDX_BITS-1:0] r_idxD;
  logic [IDX_BITS-1:0] r_idxE;
  logic                r_validD;
  logic                r_validE;
  logic                w_upd;
  logic [1:0]          w_rdCnt;
  logic [CNT_W-1:0]    r_branchCount;
  logic [CNT_W-1:0]    r_mispredCount;
  logic                w_unusedBits;

  // Only validE gates training, so a flushed or bubbled slot never touches the table
  assign w_upd = bus.StateUpdateEnable & r_validE;

`ifdef BRANCH_PREDICT_GSHARE_EN
  logic [IDX_BITS-1:0] r_ghr;

  assign w_idxF = bus.PCF[IDX_BITS+1:2] ^ r_ghr;

  // History advances only at resolution, so wrong-path fetches never pollute it
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ghr <= '0;
    end else if (w_upd) begin
      r_ghr <= {r_ghr[IDX_BITS-2:0], bus.Eval_branch};
    end
  end
`else
  assign w_idxF = bus.PCF[IDX_BITS+1:2];
`endif

  // Index/valid pipeline F->D->E; flushes take priority over stalls
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_idxD   <= '0;
      r_validD <= 1'b0;
      r_idxE   <= '0;
      r_validE <= 1'b0;
    end else begin
      if (bus.FlushD) begin
        r_validD <= 1'b0;
      end else if (!bus.StallF) begin
        r_idxD   <= w_idxF;
        r_validD <= 1'b1;
      end
      if (bus.FlushE) begin
        r_validE <= 1'b0;
      end else if (!bus.StallD) begin
        r_idxE   <= r_idxD;
        r_validE <= r_validD;
      end
    end
  end

  // Statistics wrap naturally at the counter width
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_branchCount  <= '0;
      r_mispredCount <= '0;
    end else if (w_upd) begin
      r_branchCount <= r_branchCount + 1'b1;
      if (!bus.Prediction_Correct) begin
        r_mispredCount <= r_mispredCount + 1'b1;
      end
    end
  end

  // Training always uses the index carried from fetch, never a recomputed one
  bp_counter_table #(
    .IDX_BITS (IDX_BITS)
  ) u_table (
    .clk     (clk),
    .rst     (rst),
    .i_rdIdx (w_idxF),
    .o_rdCnt (w_rdCnt),
    .i_wrIdx (r_idxE),
    .i_taken (bus.Eval_branch),
    .i_we    (w_upd)
  );

  assign bus.PredictF     = w_rdCnt[1];
  assign bus.MispredictE  = w_upd & ~bus.Prediction_Correct;
  assign bus.BranchCount  = r_branchCount;
  assign bus.MispredCount = r_mispredCount;

  // PC byte-offset bits, high PC bits and the counter LSB play no part in prediction
  assign w_unusedBits = ^{bus.PCF[31:IDX_BITS+2], bus.PCF[1:0], w_rdCnt[0]};

endmodule
